// File: rtl/keypad_pkg.sv
// Shared key codes, scanner FSM states and the row/column key map for the 4x3 keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kp_state_e;

  // Entry row*3+col; column 0 is the one driven by COL_N=110.
  localparam logic [0:11][3:0] KEY_MAP = {
    KEY_1,    KEY_2, KEY_3,
    KEY_4,    KEY_5, KEY_6,
    KEY_7,    KEY_8, KEY_9,
    KEY_STAR, KEY_0, KEY_HASH
  };

  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    idx = {2'b00, row} * 4'd3 + {2'b00, col};
    if (col == 2'd3) return KEY_NONE;
    return KEY_MAP[idx];
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to the inactive level.
module keypad_sync #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad column scanner with per-frame debounce FSM.
// Optional KEYPAD_OCTAVE_EN: '*' and '#' step a one-hot octave select instead of reporting a key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_CNT   = 50000,
  parameter int DEBOUNCE_N = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] ROW_N,
  output logic [2:0] COL_N,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_PRESS,
  output logic [2:0] OCTAVE
);

  localparam int         CW   = $clog2(SCAN_CNT);
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

  logic [3:0]    row_sync;
  logic [CW-1:0] cyc_cnt;
  logic [1:0]    col_idx;
  logic          slot_end, frame_end;
  logic [1:0]    acc_cnt, hit_cnt;
  logic [3:0]    acc_code, hit_code, raw_code;
  kp_state_e     state, state_n;
  logic [3:0]    cand, cand_n;
  logic [3:0]    db_cnt, db_cnt_n;
  logic          accept, release_done, is_oct;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (ROW_N),
    .q   (row_sync)
  );

  assign slot_end  = (cyc_cnt == CW'(SCAN_CNT - 1));
  assign frame_end = EN && slot_end && (col_idx == 2'd2);

  // Counters sit at column 0, cycle 0 while disabled, so scanning restarts there.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc_cnt <= '0;
      col_idx <= '0;
    end else if (!EN) begin
      cyc_cnt <= '0;
      col_idx <= '0;
    end else if (slot_end) begin
      cyc_cnt <= '0;
      col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

  always_comb begin
    case (col_idx)
      2'd0:    COL_N = 3'b110;
      2'd1:    COL_N = 3'b101;
      default: COL_N = 3'b011;
    endcase
    if (!EN) COL_N = 3'b111;
  end

  // Hit count saturates at 2: anything beyond one key is simply "ambiguous".
  always_comb begin
    hit_cnt  = acc_cnt;
    hit_code = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
        hit_code = key_at(2'(r), col_idx);
      end
    end
    raw_code = (hit_cnt == 2'd1) ? hit_code : KEY_NONE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_cnt  <= '0;
      acc_code <= KEY_NONE;
    end else if (!EN || frame_end) begin
      acc_cnt  <= '0;
      acc_code <= KEY_NONE;
    end else if (slot_end) begin
      acc_cnt  <= hit_cnt;
      acc_code <= hit_code;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cand   <= KEY_NONE;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      db_cnt <= db_cnt_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_n      = state;
    cand_n       = cand;
    db_cnt_n     = db_cnt;
    accept       = 1'b0;
    release_done = 1'b0;
    if (!EN) begin
      state_n  = IDLE;
      db_cnt_n = '0;
    end else if (frame_end) begin
      case (state)
        IDLE: begin
          if (raw_code != KEY_NONE) begin
            cand_n   = raw_code;
            db_cnt_n = 4'd1;
            if (DB_N == 4'd1) begin
              state_n = HELD;
              accept  = 1'b1;
            end else begin
              state_n = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (raw_code == cand) begin
            db_cnt_n = db_cnt + 4'd1;
            if (db_cnt + 4'd1 == DB_N) begin
              state_n = HELD;
              accept  = 1'b1;
            end
          end else begin
            state_n  = IDLE;
            db_cnt_n = '0;
          end
        end
        HELD: begin
          if (raw_code != cand) begin
            db_cnt_n = 4'd1;
            if (DB_N == 4'd1) begin
              state_n      = IDLE;
              db_cnt_n     = '0;
              release_done = 1'b1;
            end else begin
              state_n = RELEASE_WAIT;
            end
          end
        end
        default: begin
          if (raw_code == cand) begin
            state_n = HELD;
          end else if (db_cnt + 4'd1 == DB_N) begin
            state_n      = IDLE;
            db_cnt_n     = '0;
            release_done = 1'b1;
          end else begin
            db_cnt_n = db_cnt + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef KEYPAD_OCTAVE_EN
  assign is_oct = (cand_n == KEY_STAR) || (cand_n == KEY_HASH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OCTAVE <= 3'b001;
    end else if (EN && accept) begin
      if (cand_n == KEY_STAR && OCTAVE != 3'b001) OCTAVE <= OCTAVE >> 1;
      if (cand_n == KEY_HASH && OCTAVE != 3'b100) OCTAVE <= OCTAVE << 1;
    end
  end
`else
  assign is_oct = 1'b0;
  assign OCTAVE = 3'b001;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      KEY_CODE  <= KEY_NONE;
      KEY_VALID <= 1'b0;
      KEY_PRESS <= 1'b0;
    end else begin
      KEY_PRESS <= 1'b0;
      if (!EN) begin
        KEY_VALID <= 1'b0;
      end else if (accept && !is_oct) begin
        KEY_CODE  <= cand_n;
        KEY_VALID <= 1'b1;
        KEY_PRESS <= 1'b1;
      end else if (release_done) begin
        KEY_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: frame-level behavioural model with directed and random key patterns.
// Octave-command expectations follow KEYPAD_OCTAVE_EN when it is defined for the build.
module tb_keypad_scan;

  localparam int SCAN  = 4;
  localparam int DBN   = 3;
  localparam int FRAME = 3 * SCAN;
`ifdef KEYPAD_OCTAVE_EN
  localparam bit OCT_EN = 1'b1;
`else
  localparam bit OCT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_press;
  logic [2:0]  octave;
  logic [11:0] pressed;

  int checks   = 0;
  int failures = 0;

  // Physical keypad: bit row*3+col, in the same order as the key table below.
  logic [3:0] key_tab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};

  // Model state: abstract "holding" flag, run/miss frame counts.
  bit         m_holding;
  int         m_run, m_miss, m_oct;
  logic [3:0] m_cand, m_code;
  logic       m_valid, m_press;

  keypad_scan #(.SCAN_CNT(SCAN), .DEBOUNCE_N(DBN)) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .ROW_N     (row_n),
    .COL_N     (col_n),
    .KEY_CODE  (key_code),
    .KEY_VALID (key_valid),
    .KEY_PRESS (key_press),
    .OCTAVE    (octave)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] frame_raw(input logic [11:0] k);
    if ($countones(k) != 1) return 4'hF;
    for (int i = 0; i < 12; i++)
      if (k[i]) return key_tab[i];
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_holding = 0; m_run = 0; m_miss = 0; m_oct = 0;
    m_cand = 4'hF; m_code = 4'hF; m_valid = 0; m_press = 0;
  endtask

  task automatic model_disable();
    m_holding = 0; m_run = 0; m_miss = 0; m_valid = 0; m_press = 0;
  endtask

  task automatic model_frame(input logic [3:0] raw);
    m_press = 0;
    if (!m_holding) begin
      if (m_run == 0) begin
        if (raw != 4'hF) begin m_cand = raw; m_run = 1; end
      end else if (raw == m_cand) m_run++;
      else m_run = 0;
      if (m_run == DBN) begin
        m_holding = 1; m_run = 0; m_miss = 0;
        if (OCT_EN && m_cand == 4'hA) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
        else if (OCT_EN && m_cand == 4'hB) m_oct = (m_oct < 2) ? m_oct + 1 : 2;
        else begin m_valid = 1; m_code = m_cand; m_press = 1; end
      end
    end else if (raw != m_cand) begin
      m_miss++;
      if (m_miss == DBN) begin m_holding = 0; m_valid = 0; m_miss = 0; end
    end else begin
      m_miss = 0;
    end
  endtask

  // Runs one aligned frame with the given keys down; starts and ends on a negedge.
  task automatic run_frame(input logic [11:0] keys, input string tag);
    int stray = 0;
    pressed = keys;
    for (int i = 0; i < FRAME; i++) begin
      if (i % SCAN == 1) check({tag, ":col"}, 32'(col_n), 32'(3'b111 ^ (3'b001 << (i / SCAN))));
      if (i > 0 && key_press) stray++;
      @(posedge clk); @(negedge clk);
    end
    model_frame(frame_raw(keys));
    check({tag, ":press_stray"}, 32'(stray), 32'(0));
    check({tag, ":press"}, 32'(key_press), 32'(m_press));
    check({tag, ":valid"}, 32'(key_valid), 32'(m_valid));
    check({tag, ":code"}, 32'(key_code), 32'(m_code));
    check({tag, ":octave"}, 32'(octave), 32'(3'b001 << m_oct));
  endtask

  task automatic hold(input logic [11:0] keys, input int n, input string tag);
    for (int f = 0; f < n; f++) run_frame(keys, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  localparam logic [11:0] K1 = 12'b1 << 0,  K2 = 12'b1 << 1,  K3 = 12'b1 << 2;
  localparam logic [11:0] K4 = 12'b1 << 3,  K5 = 12'b1 << 4,  K6 = 12'b1 << 5;
  localparam logic [11:0] K8 = 12'b1 << 7,  KSTAR = 12'b1 << 9;
  localparam logic [11:0] K0 = 12'b1 << 10, KHASH = 12'b1 << 11;

  initial begin
    rst = 1'b1; en = 1'b1; pressed = '0;
    model_reset();
    #1;
    check("rst:col", 32'(col_n), 32'(3'b110));
    check("rst:code", 32'(key_code), 32'(4'hF));
    check("rst:valid", 32'(key_valid), 32'(0));
    check("rst:press", 32'(key_press), 32'(0));
    check("rst:octave", 32'(octave), 32'(3'b001));
    @(negedge clk);
    rst = 1'b0;

    // Two keys together are ambiguous; dropping one leaves a valid single key.
    hold(K1 | K2, 3, "dual");
    hold(K1, 4, "dual_release2");
    hold('0, 3, "dual_release");

    // Clean press of 5 held 10 frames, then released.
    hold(K5, 10, "press5");
    hold('0, 4, "release5");

    // Bouncing 8: present, absent, then steady.
    run_frame(K8, "bounce8");
    run_frame('0, "bounce8");
    hold(K8, 4, "bounce8");
    hold('0, 3, "bounce8_rel");

    // Key change without a gap: release debounce then press debounce.
    hold(K4, 4, "chg4");
    hold(K6, 8, "chg6");
    hold('0, 3, "chg_rel");

    // '#' three times then '*' once: octave commands or plain B/A keys.
    for (int n = 0; n < 3; n++) begin
      hold(KHASH, 4, "hash");
      hold('0, 3, "hash_rel");
    end
    hold(KSTAR, 4, "star");
    hold('0, 3, "star_rel");

    // Reset while holding 0, key stays down across reset.
    hold(K0, 4, "rst0");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid:valid", 32'(key_valid), 32'(0));
    check("rst_mid:code", 32'(key_code), 32'(4'hF));
    check("rst_mid:col", 32'(col_n), 32'(3'b110));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    hold(K0, 4, "rst0_again");
    hold('0, 3, "rst0_rel");

    // EN dropped mid-frame while 3 is held.
    hold(K3, 4, "en3");
    repeat (6) @(negedge clk);
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("en_off:col", 32'(col_n), 32'(3'b111));
    check("en_off:valid", 32'(key_valid), 32'(0));
    repeat (7) @(negedge clk);
    check("en_off_hold:col", 32'(col_n), 32'(3'b111));
    check("en_off_hold:press", 32'(key_press), 32'(0));
    en = 1'b1;
    model_disable();
    hold(K3, 4, "en3_again");
    hold('0, 3, "en3_rel");

    // Random segments: none, single key, or two keys, each held a few frames.
    for (int s = 0; s < 60; s++) begin
      logic [11:0] k;
      int sel;
      sel = $urandom_range(0, 6);
      k = '0;
      if (sel >= 1 && sel <= 5) k[$urandom_range(0, 11)] = 1'b1;
      else if (sel == 6) begin
        k[$urandom_range(0, 11)] = 1'b1;
        k[$urandom_range(0, 11)] = 1'b1;
      end
      hold(k, $urandom_range(1, 5), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_CNT, default 50000: CLK cycles each column is driven, range 4..2^20.
REQ-002 SHALL have parameter DEBOUNCE_N, default 3: consecutive identical full-frame samples required to accept a press or release, range 1..15.
REQ-003 SHALL have port CLK, input, 1: single clock for all logic.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port EN, input, 1: scan enable.
REQ-006 SHALL have port ROW_N, input, 4: keypad rows, active-low, asynchronous to CLK.
REQ-007 SHALL have port COL_N, output, 3: keypad column drive, active-low one-hot.
REQ-008 SHALL have port KEY_CODE, output, 4: debounced key code; feeds the tone converter B_in.
REQ-009 SHALL have port KEY_VALID, output, 1: high while the accepted key is held; feeds the tone converter EN.
REQ-010 SHALL have port KEY_PRESS, output, 1: one-cycle pulse on key acceptance.
REQ-011 SHALL have port OCTAVE, output, 3: one-hot octave select; feeds the tone converter octave.

Function
REQ-012 SHALL synchronise ROW_N through two flops before any use.
REQ-013 SHALL drive COL_N as 110, then 101, then 011, then repeat, with SCAN_CNT cycles per column; one frame is 3*SCAN_CNT cycles.
REQ-014 SHALL sample the synchronised rows on the last cycle of each column slot.
REQ-015 SHALL use this key map, as row/col: code. r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: *=4'hA, 0=4'h0, #=4'hB.
REQ-016 SHALL set the raw frame code to 4'hF (none) when zero keys or two or more keys are detected in a frame.
REQ-017 SHALL evaluate the raw code once per frame end, using FSM states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-018 SHALL implement these FSM transitions:
- IDLE -> PRESS_WAIT on a raw code other than F; the debounce counter loads 1.
- PRESS_WAIT: the counter increments on a raw code equal to the candidate; on reaching DEBOUNCE_N, go to HELD; on a differing code, go to IDLE.
- HELD: any raw code differing from the held code goes to RELEASE_WAIT with the counter at 1.
- RELEASE_WAIT: DEBOUNCE_N consecutive differing frames go to IDLE; a frame equal to the held code returns to HELD.
REQ-019 SHALL register KEY_CODE, assert KEY_VALID, and pulse KEY_PRESS in the cycle after the HELD entry, which is DEBOUNCE_N frames after the first qualifying frame.
REQ-020 SHALL deassert KEY_VALID one cycle after the RELEASE_WAIT -> IDLE transition, while KEY_CODE retains the last accepted code.
REQ-021 SHALL only accept a key change (A to B without a gap) after release debounce to IDLE followed by press debounce.
REQ-022 SHALL, while EN=0, freeze the column and frame counters, drive COL_N=111, force the FSM to IDLE, clear KEY_VALID and KEY_PRESS, and hold OCTAVE.
REQ-023 SHALL, when EN rises, restart the scan at column 0, cycle 0.

Reset
REQ-024 SHALL, on RST asserted, asynchronously set COL_N=110, KEY_CODE=4'hF, KEY_VALID=0, KEY_PRESS=0, OCTAVE=001, FSM=IDLE, and all counters to 0.
REQ-025 SHALL, on RST mid-press, discard the press, so the key must be re-debounced in full after release of RST.

Configuration
REQ-026 SHALL, with KEYPAD_OCTAVE_EN defined, treat * and # on HELD entry as octave commands:
- * shifts OCTAVE one position toward 001, saturating at 001.
- # shifts OCTAVE one position toward 100, saturating at 100.
- KEY_VALID and KEY_PRESS stay 0 for these keys, and KEY_CODE is unchanged.
REQ-027 SHALL, without KEYPAD_OCTAVE_EN, tie OCTAVE to 001 and handle * and # as ordinary keys, outputting A and B.

Structure
REQ-028 SHALL place the key code constants (0..9, A, B, F), the FSM state enum and the key map table in package keypad_pkg.
REQ-029 SHALL implement the two-flop row synchroniser as sub-module keypad_sync, parameterised by width.

Verification
REQ-030 SHALL verify, with SCAN_CNT=4 and DEBOUNCE_N=3, a clean press of "5" (row1, col1) held 10 frames: KEY_PRESS pulses once, KEY_VALID=1, KEY_CODE=5; after release, KEY_VALID=0 after 3 frames, and KEY_CODE stays 5.
REQ-031 SHALL verify that "8" bouncing (present, absent, present, present, present frames) gives KEY_VALID only after 3 consecutive present frames, and exactly one KEY_PRESS.
REQ-032 SHALL verify that "1" and "2" pressed together give KEY_VALID=0 and KEY_CODE=F; releasing "2" leaves "1", which is accepted after 3 frames.
REQ-033 SHALL verify, with KEYPAD_OCTAVE_EN defined:
- # pressed 3 times gives OCTAVE 010, then 100, then 100 (saturated).
- * pressed once gives 010.
- KEY_VALID never asserts during these presses.
REQ-034 SHALL verify that RST asserted while HELD on "0" immediately gives KEY_VALID=0, KEY_CODE=F, COL_N=110; with the key still held after RST, re-acceptance takes 3 frames.
REQ-035 SHALL verify that EN dropped mid-frame while "3" is held gives COL_N=111 and KEY_VALID=0; when EN rises, scanning restarts at column 0 and "3" is re-accepted after 3 frames.
